// File: rtl/host_mem_axi_master.sv
// Single-outstanding AXI4 initiator: turns a command + write/read stream into one
// INCR burst on the hostMem port and reports the worst response on a done channel.
module host_mem_axi_master #(
    parameter int HOSTMEM_DATA_WIDTH = 32,
    parameter int HOSTMEM_ADDR_WIDTH = 16,
    parameter int HOSTMEM_STRB_WIDTH = HOSTMEM_DATA_WIDTH/8,
    parameter int HOSTMEM_ID_WIDTH   = 8,
    parameter int TXN_ID             = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic                          i_cmd_write,
    input  logic [HOSTMEM_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [7:0]                    i_cmd_len,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [HOSTMEM_DATA_WIDTH-1:0] i_wr_data,
    input  logic [HOSTMEM_STRB_WIDTH-1:0] i_wr_strb,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [HOSTMEM_DATA_WIDTH-1:0] o_rd_data,
    output logic                          o_rd_last,
    output logic                          o_done_valid,
    input  logic                          i_done_ready,
    output logic [1:0]                    o_done_resp,
    output logic                          o_done_mismatch,
    output logic                          o_hostMem_awvalid,
    input  logic                          i_hostMem_awready,
    output logic [HOSTMEM_ID_WIDTH-1:0]   o_hostMem_awid,
    output logic [HOSTMEM_ADDR_WIDTH-1:0] o_hostMem_awaddr,
    output logic [7:0]                    o_hostMem_awlen,
    output logic [2:0]                    o_hostMem_awsize,
    output logic [1:0]                    o_hostMem_awburst,
    output logic                          o_hostMem_awlock,
    output logic [3:0]                    o_hostMem_awcache,
    output logic [2:0]                    o_hostMem_awprot,
    output logic                          o_hostMem_wvalid,
    input  logic                          i_hostMem_wready,
    output logic [HOSTMEM_DATA_WIDTH-1:0] o_hostMem_wdata,
    output logic [HOSTMEM_STRB_WIDTH-1:0] o_hostMem_wstrb,
    output logic                          o_hostMem_wlast,
    input  logic                          i_hostMem_bvalid,
    output logic                          o_hostMem_bready,
    input  logic [HOSTMEM_ID_WIDTH-1:0]   i_hostMem_bid,
    input  logic [1:0]                    i_hostMem_bresp,
    output logic                          o_hostMem_arvalid,
    input  logic                          i_hostMem_arready,
    output logic [HOSTMEM_ID_WIDTH-1:0]   o_hostMem_arid,
    output logic [HOSTMEM_ADDR_WIDTH-1:0] o_hostMem_araddr,
    output logic [7:0]                    o_hostMem_arlen,
    output logic [2:0]                    o_hostMem_arsize,
    output logic [1:0]                    o_hostMem_arburst,
    output logic                          o_hostMem_arlock,
    output logic [3:0]                    o_hostMem_arcache,
    output logic [2:0]                    o_hostMem_arprot,
    input  logic                          i_hostMem_rvalid,
    output logic                          o_hostMem_rready,
    input  logic [HOSTMEM_ID_WIDTH-1:0]   i_hostMem_rid,
    input  logic [HOSTMEM_DATA_WIDTH-1:0] i_hostMem_rdata,
    input  logic [1:0]                    i_hostMem_rresp,
    input  logic                          i_hostMem_rlast
);
    localparam logic [2:0]                  LP_SIZE = 3'($clog2(HOSTMEM_STRB_WIDTH));
    localparam logic [HOSTMEM_ID_WIDTH-1:0] LP_ID   = HOSTMEM_ID_WIDTH'(TXN_ID);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                  r_state, w_next;
    logic                    r_active;
    logic [HOSTMEM_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]              r_len, r_cnt;
    logic [1:0]              r_resp;
    logic                    r_mismatch;
    logic                    w_wbeat, w_rbeat;
    logic                    w_unused_ids;

    // Response IDs are not checked: only one transaction is ever in flight.
    assign w_unused_ids = ^{i_hostMem_bid, i_hostMem_rid};
    assign w_wbeat      = (r_state == S_W) && i_wr_valid && i_hostMem_wready;
    assign w_rbeat      = (r_state == S_R) && i_hostMem_rvalid && i_rd_ready;

    // r_active keeps cmd_ready low until the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_active   <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_resp     <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_active <= 1'b1;
            case (r_state)
                S_IDLE: if (i_cmd_valid && r_active) begin
                    r_addr <= i_cmd_addr;
                    r_len  <= i_cmd_len;
                end
                S_W: if (w_wbeat) r_cnt <= r_cnt + 8'd1;
                S_B: if (i_hostMem_bvalid) r_resp <= i_hostMem_bresp;
                S_R: if (w_rbeat) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (i_hostMem_rresp > r_resp) r_resp <= i_hostMem_rresp;
                    if (i_hostMem_rlast) r_mismatch <= (r_cnt != r_len);
                end
                S_DONE: if (i_done_ready) begin
                    r_resp     <= '0;
                    r_mismatch <= 1'b0;
                    r_cnt      <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_cmd_valid && r_active) w_next = i_cmd_write ? S_AW : S_AR;
            S_AW:   if (i_hostMem_awready) w_next = S_W;
            S_W:    if (w_wbeat && (r_cnt == r_len)) w_next = S_B;
            S_B:    if (i_hostMem_bvalid) w_next = S_DONE;
            S_AR:   if (i_hostMem_arready) w_next = S_R;
            S_R:    if (w_rbeat && i_hostMem_rlast) w_next = S_DONE;
            S_DONE: if (i_done_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address-channel fields are only driven while the matching valid is high.
    always_comb begin
        o_cmd_ready       = (r_state == S_IDLE) && r_active;
        o_done_valid      = (r_state == S_DONE);
        o_done_resp       = r_resp;
        o_done_mismatch   = r_mismatch;
        o_hostMem_awvalid = 1'b0;
        o_hostMem_awid    = '0;
        o_hostMem_awaddr  = '0;
        o_hostMem_awlen   = '0;
        o_hostMem_awsize  = '0;
        o_hostMem_awburst = '0;
        o_hostMem_awlock  = 1'b0;
        o_hostMem_awcache = '0;
        o_hostMem_awprot  = '0;
        o_hostMem_arvalid = 1'b0;
        o_hostMem_arid    = '0;
        o_hostMem_araddr  = '0;
        o_hostMem_arlen   = '0;
        o_hostMem_arsize  = '0;
        o_hostMem_arburst = '0;
        o_hostMem_arlock  = 1'b0;
        o_hostMem_arcache = '0;
        o_hostMem_arprot  = '0;
        o_hostMem_wvalid  = 1'b0;
        o_hostMem_wdata   = '0;
        o_hostMem_wstrb   = '0;
        o_hostMem_wlast   = 1'b0;
        o_wr_ready        = 1'b0;
        o_hostMem_bready  = (r_state == S_B);
        o_hostMem_rready  = 1'b0;
        o_rd_valid        = 1'b0;
        o_rd_data         = '0;
        o_rd_last         = 1'b0;
        case (r_state)
            S_AW: begin
                o_hostMem_awvalid = 1'b1;
                o_hostMem_awid    = LP_ID;
                o_hostMem_awaddr  = r_addr;
                o_hostMem_awlen   = r_len;
                o_hostMem_awsize  = LP_SIZE;
                o_hostMem_awburst = 2'b01;
                o_hostMem_awcache = 4'b0011;
            end
            S_AR: begin
                o_hostMem_arvalid = 1'b1;
                o_hostMem_arid    = LP_ID;
                o_hostMem_araddr  = r_addr;
                o_hostMem_arlen   = r_len;
                o_hostMem_arsize  = LP_SIZE;
                o_hostMem_arburst = 2'b01;
                o_hostMem_arcache = 4'b0011;
            end
            S_W: begin
                o_hostMem_wvalid = i_wr_valid;
                o_hostMem_wdata  = i_wr_data;
                o_hostMem_wstrb  = i_wr_strb;
                o_hostMem_wlast  = (r_cnt == r_len);
                o_wr_ready       = i_hostMem_wready;
            end
            S_R: begin
                o_rd_valid       = i_hostMem_rvalid;
                o_rd_data        = i_hostMem_rdata;
                o_rd_last        = i_hostMem_rlast;
                o_hostMem_rready = i_rd_ready;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_host_mem_axi_master.sv
// Directed bench for host_mem_axi_master with a small behavioural AXI memory.
module tb_host_mem_axi_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [15:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [31:0] wr_data = 0;
    logic [3:0]  wr_strb = 0;
    logic        rd_valid, rd_ready = 0, rd_last;
    logic [31:0] rd_data;
    logic        done_valid, done_ready = 0, done_mismatch;
    logic [1:0]  done_resp;
    logic        awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
    logic [7:0]  awid, awlen, bid, arid, arlen, rid;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, bresp, arburst, rresp;
    logic [3:0]  awcache, arcache, wstrb;
    logic [31:0] wdata, rdata;
    logic        arvalid, arready, arlock, rvalid, rready, rlast;

    always #5 clk = ~clk;

    host_mem_axi_master dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
        .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data), .i_wr_strb(wr_strb),
        .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data), .o_rd_last(rd_last),
        .o_done_valid(done_valid), .i_done_ready(done_ready), .o_done_resp(done_resp),
        .o_done_mismatch(done_mismatch),
        .o_hostMem_awvalid(awvalid), .i_hostMem_awready(awready), .o_hostMem_awid(awid),
        .o_hostMem_awaddr(awaddr), .o_hostMem_awlen(awlen), .o_hostMem_awsize(awsize),
        .o_hostMem_awburst(awburst), .o_hostMem_awlock(awlock), .o_hostMem_awcache(awcache),
        .o_hostMem_awprot(awprot),
        .o_hostMem_wvalid(wvalid), .i_hostMem_wready(wready), .o_hostMem_wdata(wdata),
        .o_hostMem_wstrb(wstrb), .o_hostMem_wlast(wlast),
        .i_hostMem_bvalid(bvalid), .o_hostMem_bready(bready), .i_hostMem_bid(bid),
        .i_hostMem_bresp(bresp),
        .o_hostMem_arvalid(arvalid), .i_hostMem_arready(arready), .o_hostMem_arid(arid),
        .o_hostMem_araddr(araddr), .o_hostMem_arlen(arlen), .o_hostMem_arsize(arsize),
        .o_hostMem_arburst(arburst), .o_hostMem_arlock(arlock), .o_hostMem_arcache(arcache),
        .o_hostMem_arprot(arprot),
        .i_hostMem_rvalid(rvalid), .o_hostMem_rready(rready), .i_hostMem_rid(rid),
        .i_hostMem_rdata(rdata), .i_hostMem_rresp(rresp), .i_hostMem_rlast(rlast)
    );

    // Behavioural memory: 64 words, configurable awready stall, injected rresp, short bursts.
    logic [31:0] mem [0:63];
    logic [5:0]  m_wptr, m_rptr;
    logic [7:0]  m_rbeat, m_rlen;
    logic        m_ract, m_bpend;
    int          m_awwait, aw_stall = 0, err_beat = -1, n_aw = 0;
    bit          short_burst = 0;

    assign awready = (m_awwait >= aw_stall);
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign bvalid  = m_bpend;
    assign bresp   = 2'd0;
    assign bid     = 8'd0;
    assign rid     = 8'd0;
    assign rvalid  = m_ract;
    assign rdata   = mem[m_rptr];
    assign rlast   = (m_rbeat == m_rlen);
    assign rresp   = (int'(m_rbeat) == err_beat) ? 2'd2 : 2'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bpend <= 1'b0; m_ract <= 1'b0; m_awwait <= 0;
            m_wptr <= '0; m_rptr <= '0; m_rbeat <= '0; m_rlen <= '0;
        end else begin
            if (awvalid && !awready) m_awwait <= m_awwait + 1;
            if (awvalid && awready) begin
                m_wptr <= awaddr[7:2]; m_awwait <= 0; n_aw <= n_aw + 1;
            end
            if (wvalid && wready) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) mem[m_wptr][8*b +: 8] <= wdata[8*b +: 8];
                m_wptr <= m_wptr + 6'd1;
                if (wlast) m_bpend <= 1'b1;
            end
            if (bvalid && bready) m_bpend <= 1'b0;
            if (arvalid && arready) begin
                m_rptr <= araddr[7:2]; m_rbeat <= '0; m_ract <= 1'b1;
                m_rlen <= short_burst ? arlen - 8'd1 : arlen;
            end
            if (rvalid && rready) begin
                m_rptr <= m_rptr + 6'd1; m_rbeat <= m_rbeat + 8'd1;
                if (rlast) m_ract <= 1'b0;
            end
        end
    end

    int n_chk = 0, n_pass = 0;
    logic [31:0] wbuf [0:7];
    logic [31:0] rbuf [0:15];
    logic        rlst [0:15];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Entered and left at posedge+1; DUT outputs are sampled at posedge+2.
    task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [3:0] s,
                            input bit hold, output int cyc, output logic [1:0] resp,
                            output bit stable);
        int t;
        stable = 1;
        cmd_write = 1; cmd_addr = a; cmd_len = l; cmd_valid = 1; #1;
        t = 0;
        while (!cmd_ready && t < 100) begin @(posedge clk); #2; t++; end
        @(posedge clk); #1;
        if (!hold) cmd_valid = 0;
        cyc = 1;
        wr_valid = 1; wr_strb = s; wr_data = wbuf[0]; #1;
        chk("awvalid", awvalid, 1);
        chk("awaddr", awaddr, a);
        chk("awlen", awlen, l);
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, 2'b01);
        chk("awcache", awcache, 4'b0011);
        chk("w_before_aw", wvalid, 0);
        for (int i = 0; i <= int'(l); i++) begin
            wr_data = wbuf[i]; #1;
            t = 0;
            while (!wvalid && t < 100) begin
                if (cmd_ready || !awvalid || awaddr != a || awlen != l) stable = 0;
                @(posedge clk); #2; cyc++; t++;
            end
            chk("wlast", wlast, (i == int'(l)));
            @(posedge clk); #1; cyc++;
        end
        wr_valid = 0; #1;
        t = 0;
        while (!done_valid && t < 100) begin @(posedge clk); #2; cyc++; t++; end
        resp = done_resp;
        cmd_valid = 0; done_ready = 1;
        @(posedge clk); #1; done_ready = 0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] l, input bit tog,
                           output int nb, output logic [1:0] resp, output logic mism);
        int t;
        cmd_write = 0; cmd_addr = a; cmd_len = l; cmd_valid = 1; #1;
        t = 0;
        while (!cmd_ready && t < 100) begin @(posedge clk); #2; t++; end
        @(posedge clk); #1;
        cmd_valid = 0; nb = 0; rd_ready = 0;
        chk("arlen", arlen, l);
        t = 0;
        while (!done_valid && t < 400) begin
            rd_ready = tog ? !rd_ready : 1'b1; #1;
            if (rd_valid && rd_ready && nb < 16) begin
                rbuf[nb] = rd_data; rlst[nb] = rd_last; nb++;
            end
            @(posedge clk); #1; t++;
        end
        rd_ready = 0; #1;
        chk("rd_done", done_valid, 1);
        resp = done_resp; mism = done_mismatch;
        done_ready = 1;
        @(posedge clk); #1; done_ready = 0;
    endtask

    initial begin
        int cyc, nb, aw0;
        logic [1:0] resp;
        logic mism;
        bit stable;

        repeat (3) @(posedge clk); #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_bready", bready, 0);
        rst = 0; #1;
        chk("rel_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rel_cmd_ready_high", cmd_ready, 1);

        wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222;
        wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
        aw0 = n_aw;
        do_write(16'h0040, 8'd3, 4'hF, 0, cyc, resp, stable);
        chk("wr4_cycles", cyc, 7);
        chk("wr4_resp", resp, 0);
        chk("wr4_aw_count", n_aw - aw0, 1);

        do_read(16'h0040, 8'd3, 1, nb, resp, mism);
        chk("rd4_beats", nb, 4);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_data", rbuf[i], wbuf[i]);
            chk("rd4_last", rlst[i], (i == 3));
        end
        chk("rd4_resp", resp, 0);
        chk("rd4_mismatch", mism, 0);

        wbuf[0] = 32'hAABBCCDD;
        do_write(16'h0040, 8'd0, 4'h3, 0, cyc, resp, stable);
        chk("wr1_cycles", cyc, 4);
        do_read(16'h0040, 8'd0, 0, nb, resp, mism);
        chk("rd1_beats", nb, 1);
        chk("rd1_merge", rbuf[0], 32'h1111CCDD);
        chk("rd1_last", rlst[0], 1);

        err_beat = 1;
        do_read(16'h0040, 8'd3, 0, nb, resp, mism);
        err_beat = -1;
        chk("rderr_beats", nb, 4);
        chk("rderr_resp", resp, 2);
        chk("rderr_data3", rbuf[3], 32'h44444444);

        short_burst = 1;
        do_read(16'h0040, 8'd3, 0, nb, resp, mism);
        short_burst = 0;
        chk("short_beats", nb, 3);
        chk("short_last", rlst[2], 1);
        chk("short_mismatch", mism, 1);

        // Reset during the W phase of an 8-beat write, after three beats.
        cmd_write = 1; cmd_addr = 16'h0080; cmd_len = 8'd7; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0; wr_valid = 1; wr_strb = 4'hF; wr_data = 32'hDEAD0000;
        repeat (4) @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("mid_rst_wvalid", wvalid, 0);
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_done_valid", done_valid, 0);
        rst = 0; wr_valid = 0; #1;
        chk("post_rst_cmd_ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        chk("post_rst_cmd_ready_high", cmd_ready, 1);
        wbuf[0] = 32'h55555555; wbuf[1] = 32'h66666666;
        do_write(16'h0080, 8'd1, 4'hF, 0, cyc, resp, stable);
        chk("post_rst_wr_cycles", cyc, 5);
        do_read(16'h0080, 8'd1, 0, nb, resp, mism);
        chk("post_rst_rd0", rbuf[0], 32'h55555555);
        chk("post_rst_rd1", rbuf[1], 32'h66666666);

        aw_stall = 10;
        aw0 = n_aw;
        wbuf[0] = 32'h0BADF00D;
        do_write(16'h0020, 8'd0, 4'hF, 1, cyc, resp, stable);
        aw_stall = 0;
        chk("stall_stable", stable, 1);
        chk("stall_cycles", cyc, 14);
        repeat (3) @(posedge clk); #1;
        chk("stall_aw_count", n_aw - aw0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
